ps2_mouse_ctrl: RTL and testbench
=================================

# ps2_mouse_ctrl

Host-side sequencer for one PS/2 mouse channel. It drives the existing byte-level `ps2tx`/`ps2rx` pair: it issues the reset/enable command script, checks each response, then frames 3-byte stream-mode packets. Each packet becomes a clamped absolute cursor position plus button state for the VGA overlay. It recovers by itself from bad responses, lost bytes and (optionally) a silent device.

## Interface
Parameters:
- `X_MAX`, default 639: largest cursor x; x is clamped to [0, X_MAX].
- `Y_MAX`, default 479: largest cursor y; y is clamped to [0, Y_MAX].
- `TIMEOUT_CYCLES`, default 2_500_000: wait limit per awaited byte, in clk cycles.

Ports (name, direction, width, meaning):
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high, on clock `clk`.
- `rx_done_tick`, in, 1: one-cycle strobe, `rx_dout` valid.
- `rx_dout`, in, 8: received byte.
- `tx_done_tick`, in, 1: one-cycle strobe, command byte sent.
- `wr_ps2`, out, 1: request transmit of `din`.
- `din`, out, 8: command byte.
- `mouse_x`, out, 10: cursor x.
- `mouse_y`, out, 10: cursor y (screen orientation, down is positive).
- `buttons`, out, 3: {middle, right, left}.
- `pkt_valid`, out, 1: one-cycle pulse, all position outputs just updated.
- `init_done`, out, 1: high while in stream mode.
- `retry_cnt`, out, 4: count of init restarts; saturates at 15.

## Operation
States and transitions:
- `S_RST_CMD`: `wr_ps2`=1, `din`=8'hFF. On `tx_done_tick` go to `S_ACK1`.
- `S_ACK1`: expect 8'hFA, then go to `S_BAT`.
- `S_BAT`: expect 8'hAA, then go to `S_ID`.
- `S_ID`: expect 8'h00, then go to `S_EN_CMD`.
- `S_EN_CMD`: `wr_ps2`=1, `din`=8'hF4. On `tx_done_tick` go to `S_ACK2`.
- `S_ACK2`: expect 8'hFA, then go to `S_PKT0`; `init_done` goes high.
- `S_PKT0`: capture byte 0. If bit3=0, drop the byte and stay (resync). Otherwise go to `S_PKT1`.
- `S_PKT1`: capture dx, then go to `S_PKT2`.
- `S_PKT2`: capture dy, then go to `S_UPD`.
- `S_UPD`: one cycle. Update outputs, then go to `S_PKT0`.

Error handling:
- A received byte in any `S_ACK*`/`S_BAT`/`S_ID` state that is not the expected value sends the FSM to `S_RST_CMD` and increments `retry_cnt`. `init_done` drops.

Don't-care inputs:
- `rx_done_tick` in a CMD state is ignored.
- `tx_done_tick` outside a CMD state is ignored.

Arithmetic:
- dx = sign-extend {byte0[4], dx_byte} to 11 bits; dy likewise from byte0[5].
- If byte0[6] (x overflow) is set, dx=0. If byte0[7] (y overflow) is set, dy=0.
- x_new = x + dx; y_new = y − dy. Both are evaluated in 12-bit signed.
- Clamp: below 0 becomes 0; above MAX becomes MAX.
- `buttons` = byte0[2:0].
- Examples: x=0, dx=−5 gives 0. x=639, dx=+200 gives 639.

## Timing
- Reset values: state `S_RST_CMD`, `mouse_x`=(X_MAX+1)/2 (320), `mouse_y`=(Y_MAX+1)/2 (240), `buttons`=0, `pkt_valid`=0, `init_done`=0, `retry_cnt`=0, timeout counter 0.
- `wr_ps2` and `din` are combinational from the state. `wr_ps2` is forced to 0 while `rst`=1. It is therefore first high in the cycle after rst deasserts.
- `wr_ps2` is held high until the cycle `tx_done_tick` is seen. It is low the following cycle.
- A byte accepted on cycle N advances the state at N+1.
- Latency: `mouse_x`, `mouse_y`, `buttons`, `pkt_valid` all change on the edge ending `S_UPD`. That is 2 cycles after the `rx_done_tick` for dy.
- `rst` mid-packet or mid-init aborts immediately; no partial update is applied.
- Timeout counter clears on every state change and on every `rx_done_tick`. It counts only in `S_ACK*`, `S_BAT`, `S_ID`, `S_PKT1` and `S_PKT2`.

## Configuration
- `PS2_MOUSE_TIMEOUT_EN` defined:
  - Counter reaching TIMEOUT_CYCLES−1 in an init wait state goes to `S_RST_CMD` and increments `retry_cnt`.
  - In `S_PKT1`/`S_PKT2`, the partial packet is discarded and the FSM goes to `S_PKT0`. `retry_cnt` is unchanged.
  - `S_PKT0` never times out.
- Not defined: no counter logic is present; wait states wait forever.

## Test plan
- Nominal init: device model answers FA, AA, 00, then FA after F4. Required: exactly two transmits (FF, F4); `init_done`=1 one cycle after the final FA; `retry_cnt`=0.
- Bad ack: answer FE instead of FA after FF. Required: FSM back in `S_RST_CMD`; `retry_cnt`=1; FF re-sent; a correct second sequence then completes.
- Packet update: after init, send 08,05,03. Required: one `pkt_valid` pulse; (320,240) becomes (325,237); `buttons`=0.
- Sign and clamp: send 19,FB,00 then 09,00,00. Required: x 320 becomes 315; `buttons`=3'b001. Then send 18,00,00 with x=3 (dx=−256). Required: x=0.
- Resync and overflow: send stray byte 05 (bit3=0), then 48,FF,10. Required: 05 dropped, no `pkt_valid`; the packet gives dx=0 (overflow) and y 240 becomes 224.
- Timeout (macro on, TIMEOUT_CYCLES=100): send 08,05 then go silent for 100 cycles. Required: return to `S_PKT0`, no update. A following 08,01,00 gives x+1.

Source files
------------

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse host sequencer: reset/enable command script, then 3-byte stream packet decode
// into a clamped cursor position. Define PS2_MOUSE_TIMEOUT_EN to add per-byte wait timeouts.
module ps2_mouse_ctrl #(
  parameter int unsigned X_MAX          = 639,
  parameter int unsigned Y_MAX          = 479,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  input  logic       tx_done_tick,
  output logic       wr_ps2,
  output logic [7:0] din,
  output logic [9:0] mouse_x,
  output logic [9:0] mouse_y,
  output logic [2:0] buttons,
  output logic       pkt_valid,
  output logic       init_done,
  output logic [3:0] retry_cnt
);

  typedef enum logic [3:0] {
    S_RST_CMD, S_ACK1, S_BAT, S_ID, S_EN_CMD, S_ACK2, S_PKT0, S_PKT1, S_PKT2, S_UPD
  } state_t;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  localparam logic signed [11:0] X_LIM  = 12'(X_MAX);
  localparam logic signed [11:0] Y_LIM  = 12'(Y_MAX);
  localparam logic [9:0]         X_HOME = 10'((X_MAX + 1) / 2);
  localparam logic [9:0]         Y_HOME = 10'((Y_MAX + 1) / 2);

  state_t state, state_nxt;
  logic   init_fail, timeout_hit;
  logic   cap_b0, cap_dx, cap_dy;

  logic [3:0] hdr_hi;   // byte0[7:4]: y ovf, x ovf, y sign, x sign
  logic [2:0] hdr_btn;  // byte0[2:0]
  logic [7:0] dx_byte, dy_byte;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_RST_CMD;
    else     state <= state_nxt;
  end

  // Next state, command outputs and capture strobes
  always_comb begin
    state_nxt = state;
    init_fail = 1'b0;
    cap_b0    = 1'b0;
    cap_dx    = 1'b0;
    cap_dy    = 1'b0;
    wr_ps2    = 1'b0;
    din       = CMD_RESET;
    case (state)
      S_RST_CMD: begin
        wr_ps2 = !rst;
        din    = CMD_RESET;
        if (tx_done_tick) state_nxt = S_ACK1;
      end
      S_ACK1: begin
        if (rx_done_tick) begin
          if (rx_dout == RSP_ACK) state_nxt = S_BAT;
          else                    init_fail = 1'b1;
        end else if (timeout_hit) init_fail = 1'b1;
      end
      S_BAT: begin
        if (rx_done_tick) begin
          if (rx_dout == RSP_BAT) state_nxt = S_ID;
          else                    init_fail = 1'b1;
        end else if (timeout_hit) init_fail = 1'b1;
      end
      S_ID: begin
        if (rx_done_tick) begin
          if (rx_dout == RSP_ID) state_nxt = S_EN_CMD;
          else                   init_fail = 1'b1;
        end else if (timeout_hit) init_fail = 1'b1;
      end
      S_EN_CMD: begin
        wr_ps2 = !rst;
        din    = CMD_ENABLE;
        if (tx_done_tick) state_nxt = S_ACK2;
      end
      S_ACK2: begin
        if (rx_done_tick) begin
          if (rx_dout == RSP_ACK) state_nxt = S_PKT0;
          else                    init_fail = 1'b1;
        end else if (timeout_hit) init_fail = 1'b1;
      end
      S_PKT0: begin
        // bytes without the always-one header bit are stray; drop them to resync
        if (rx_done_tick && rx_dout[3]) begin
          cap_b0    = 1'b1;
          state_nxt = S_PKT1;
        end
      end
      S_PKT1: begin
        if (rx_done_tick) begin
          cap_dx    = 1'b1;
          state_nxt = S_PKT2;
        end else if (timeout_hit) state_nxt = S_PKT0;
      end
      S_PKT2: begin
        if (rx_done_tick) begin
          cap_dy    = 1'b1;
          state_nxt = S_UPD;
        end else if (timeout_hit) state_nxt = S_PKT0;
      end
      S_UPD:   state_nxt = S_PKT0;
      default: state_nxt = S_RST_CMD;
    endcase
    if (init_fail) state_nxt = S_RST_CMD;
  end

`ifdef PS2_MOUSE_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt;
  logic            to_wait;

  assign to_wait = (state == S_ACK1) || (state == S_BAT) || (state == S_ID) ||
                   (state == S_ACK2) || (state == S_PKT1) || (state == S_PKT2);

  // Per-byte wait counter, restarted by any byte or state change
  always_ff @(posedge clk) begin
    if (rst || !to_wait || rx_done_tick || (state_nxt != state)) to_cnt <= '0;
    else                                                         to_cnt <= to_cnt + TO_W'(1);
  end

  assign timeout_hit = to_wait && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // Wait states never expire in this build
  assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  logic signed [10:0] dx, dy;
  logic signed [11:0] x_sum, y_sum;
  logic [9:0]         x_new, y_new;

  // Packet arithmetic: 9-bit two's complement deltas, overflow forces zero, clamp to screen
  always_comb begin
    dx    = hdr_hi[2] ? 11'sd0 : $signed({{2{hdr_hi[0]}}, hdr_hi[0], dx_byte});
    dy    = hdr_hi[3] ? 11'sd0 : $signed({{2{hdr_hi[1]}}, hdr_hi[1], dy_byte});
    x_sum = $signed({2'b00, mouse_x}) + $signed({dx[10], dx});
    y_sum = $signed({2'b00, mouse_y}) - $signed({dy[10], dy});
    if (x_sum < 12'sd0)      x_new = 10'd0;
    else if (x_sum > X_LIM)  x_new = X_LIM[9:0];
    else                     x_new = x_sum[9:0];
    if (y_sum < 12'sd0)      y_new = 10'd0;
    else if (y_sum > Y_LIM)  y_new = Y_LIM[9:0];
    else                     y_new = y_sum[9:0];
  end

  // Packet capture, cursor/button update and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_hi    <= '0;
      hdr_btn   <= '0;
      dx_byte   <= '0;
      dy_byte   <= '0;
      mouse_x   <= X_HOME;
      mouse_y   <= Y_HOME;
      buttons   <= '0;
      pkt_valid <= 1'b0;
      init_done <= 1'b0;
      retry_cnt <= '0;
    end else begin
      pkt_valid <= 1'b0;
      if (cap_b0) begin
        hdr_hi  <= rx_dout[7:4];
        hdr_btn <= rx_dout[2:0];
      end
      if (cap_dx) dx_byte <= rx_dout;
      if (cap_dy) dy_byte <= rx_dout;
      if (state == S_UPD) begin
        mouse_x   <= x_new;
        mouse_y   <= y_new;
        buttons   <= hdr_btn;
        pkt_valid <= 1'b1;
      end
      if (init_fail && (retry_cnt != 4'hF)) retry_cnt <= retry_cnt + 4'd1;
      init_done <= (state_nxt == S_PKT0) || (state_nxt == S_PKT1) ||
                   (state_nxt == S_PKT2) || (state_nxt == S_UPD);
    end
  end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Scoreboard bench for ps2_mouse_ctrl: device-model stimulus, queue of expected packets/commands,
// independent monitor. Timeout scenario runs only when PS2_MOUSE_TIMEOUT_EN is defined.
module tb_ps2_mouse_ctrl;
  localparam int unsigned X_MAX = 639;
  localparam int unsigned Y_MAX = 479;
  localparam int unsigned TO    = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic       tx_done_tick = 1'b0;
  logic       wr_ps2;
  logic [7:0] din;
  logic [9:0] mouse_x, mouse_y;
  logic [2:0] buttons;
  logic       pkt_valid, init_done;
  logic [3:0] retry_cnt;

  ps2_mouse_ctrl #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_done_tick(rx_done_tick), .rx_dout(rx_dout),
    .tx_done_tick(tx_done_tick), .wr_ps2(wr_ps2), .din(din), .mouse_x(mouse_x),
    .mouse_y(mouse_y), .buttons(buttons), .pkt_valid(pkt_valid), .init_done(init_done),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int btn; int at; } pkt_t;

  pkt_t       exp_q[$];
  logic [7:0] cmd_q[$];
  pkt_t       mon_e;
  int checks = 0, errors = 0, cyc = 0;
  int tx_seen = 0, tx_exp = 0, exp_retry = 0;
  int mx = 320, my = 240;
  logic wr_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops expected packets/commands whenever the DUT presents them
  always @(negedge clk) begin
    if (pkt_valid) begin
      if (exp_q.size() == 0) check("unexpected_pkt", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("pkt_x", int'(mouse_x), mon_e.x);
        check("pkt_y", int'(mouse_y), mon_e.y);
        check("pkt_btn", int'(buttons), mon_e.btn);
        check("pkt_latency", cyc, mon_e.at);
      end
    end
    if (wr_ps2 && !wr_prev) begin
      tx_seen++;
      if (cmd_q.size() == 0) check("unexpected_tx", 1, 0);
      else check("tx_din", int'(din), int'(cmd_q.pop_front()));
    end
    wr_prev = wr_ps2;
  end

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic send_byte(input logic [7:0] b, output int at);
    repeat (1 + $urandom_range(0, 2)) @(posedge clk);
    #1 rx_dout = b; rx_done_tick = 1'b1; at = cyc;
    @(posedge clk);
    #1 rx_done_tick = 1'b0;
  endtask

  // Reference: 9-bit signed deltas, overflow zeroes the delta, y axis inverted, clamp to screen
  task automatic send_packet(input logic [7:0] b0, input logic [7:0] dxb, input logic [7:0] dyb);
    int dx, dy, at;
    pkt_t e;
    send_byte(b0, at);
    send_byte(dxb, at);
    dx = b0[6] ? 0 : (b0[4] ? int'(dxb) - 256 : int'(dxb));
    dy = b0[7] ? 0 : (b0[5] ? int'(dyb) - 256 : int'(dyb));
    mx = clampi(mx + dx, X_MAX);
    my = clampi(my - dy, Y_MAX);
    send_byte(dyb, at);
    e.x = mx; e.y = my; e.btn = int'(b0[2:0]); e.at = at + 2;
    exp_q.push_back(e);
  endtask

  task automatic do_tx(input logic [7:0] cmd, input bit stray_rx);
    int n, at;
    cmd_q.push_back(cmd);
    tx_exp++;
    for (n = 0; n < 50 && !wr_ps2; n++) @(negedge clk);
    check("tx_request", int'(wr_ps2), 1);
    if (stray_rx) send_byte(8'hFA, at);
    repeat (2) @(posedge clk);
    #1 check("tx_hold", int'(wr_ps2), 1);
    tx_done_tick = 1'b1;
    @(posedge clk);
    #1 tx_done_tick = 1'b0;
    check("tx_release", int'(wr_ps2), 0);
  endtask

  task automatic do_init(input bit bad_ack);
    int at;
    do_tx(8'hFF, 1'b1);
    if (bad_ack) begin
      send_byte(8'hFE, at);
      exp_retry++;
      check("retry_after_bad", int'(retry_cnt), exp_retry);
      check("init_low_after_bad", int'(init_done), 0);
      do_tx(8'hFF, 1'b0);
    end
    send_byte(8'hFA, at);
    send_byte(8'hAA, at);
    send_byte(8'h00, at);
    do_tx(8'hF4, 1'b0);
    check("init_before_ack", int'(init_done), 0);
    send_byte(8'hFA, at);
    check("init_done", int'(init_done), 1);
    check("init_retry", int'(retry_cnt), exp_retry);
    check("tx_count", tx_seen, tx_exp);
    check("tx_queue_empty", cmd_q.size(), 0);
  endtask

  initial begin
    int at;
    logic [7:0] b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr", int'(wr_ps2), 0);
    check("rst_x", int'(mouse_x), 320);
    check("rst_y", int'(mouse_y), 240);
    check("rst_btn", int'(buttons), 0);
    check("rst_init", int'(init_done), 0);
    check("rst_retry", int'(retry_cnt), 0);
    check("rst_pkt", int'(pkt_valid), 0);
    rst = 1'b0;

    do_init(1'b1);

    // tx strobe outside a command state is ignored
    @(posedge clk); #1 tx_done_tick = 1'b1;
    @(posedge clk); #1 tx_done_tick = 1'b0;
    check("tx_ignored_wr", int'(wr_ps2), 0);
    check("tx_ignored_init", int'(init_done), 1);

    send_packet(8'h08, 8'h05, 8'h03);
    send_packet(8'h19, 8'hFB, 8'h00);
    send_packet(8'h09, 8'h00, 8'h00);
    send_byte(8'h05, at);
    send_packet(8'h48, 8'hFF, 8'h10);
    repeat (3) send_packet(8'h08, 8'hFF, 8'h00);
    repeat (3) send_packet(8'h18, 8'h00, 8'h00);
    repeat (3) send_packet(8'h08, 8'h00, 8'h7F);
    repeat (5) send_packet(8'h28, 8'h00, 8'h80);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        b0 = 8'($urandom()) & 8'hF7;
        send_byte(b0, at);
      end
      send_packet(8'($urandom()) | 8'h08, 8'($urandom()), 8'($urandom()));
    end

`ifdef PS2_MOUSE_TIMEOUT_EN
    send_byte(8'h08, at);
    send_byte(8'h05, at);
    repeat (TO + 5) @(posedge clk);
    #1 check("timeout_retry", int'(retry_cnt), exp_retry);
    send_packet(8'h08, 8'h01, 8'h00);
`endif

    // reset mid-packet discards the partial packet
    send_byte(8'h08, at);
    send_byte(8'h05, at);
    #1 rst = 1'b1;
    mx = 320; my = 240; exp_retry = 0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_x", int'(mouse_x), 320);
    check("midrst_y", int'(mouse_y), 240);
    check("midrst_init", int'(init_done), 0);
    check("midrst_retry", int'(retry_cnt), 0);
    rst = 1'b0;
    do_init(1'b0);
    send_packet(8'h0A, 8'h10, 8'hF0);

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("pkt_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
